forward_ctrl: RTL and testbench
===============================

FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, the register-index width.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, the stall-counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port id_valid  input  1  decode-stage instruction present.
REQ-006 SHALL have port id_rs1  input  REG_ADDR_WIDTH  decode source register 1.
REQ-007 SHALL have port id_rs2  input  REG_ADDR_WIDTH  decode source register 2.
REQ-008 SHALL have port id_rd  input  REG_ADDR_WIDTH  decode destination register.
REQ-009 SHALL have port id_reg_write  input  1  decode instruction writes rd.
REQ-010 SHALL have port id_mem_read  input  1  decode instruction is a load.
REQ-011 SHALL have port flush  input  1  squash the decode and EX instructions, e.g. on a taken branch.
REQ-012 SHALL have port stall  output  1  load-use hazard; decode and fetch hold.
REQ-013 SHALL have port ex_sel_a  output  2  operand-A select for the EX-stage 3-input operand mux.
REQ-014 SHALL have port ex_sel_b  output  2  operand-B select for the EX-stage 3-input operand mux.
REQ-015 SHALL have port ex_valid  output  1  EX stage holds a live instruction.
REQ-016 SHALL have port stall_count  output  CNT_WIDTH  number of load-use stall cycles since reset.

Function
REQ-017 SHALL keep three internal tracking stages: EX {valid, rs1, rs2, rd, reg_write, mem_read}, MEM {valid, rd, reg_write}, WB {valid, rd, reg_write}.
REQ-018 SHALL use select encoding 2'b00 = register-file value, 2'b01 = EX/MEM result, 2'b10 = MEM/WB result; 2'b11 is never driven.
REQ-019 SHALL compute ex_sel_a combinationally from registered state: 01 if MEM.valid & MEM.reg_write & MEM.rd!=0 & MEM.rd==EX.rs1; else 10 if the same test passes against WB; else 00.
REQ-020 SHALL compute ex_sel_b identically to ex_sel_a, using EX.rs2.
REQ-021 SHALL give the MEM match priority over the WB match when both hit; a match on rd==0 SHALL never forward.
REQ-022 SHALL force ex_sel_a and ex_sel_b to 00 when EX.valid=0.
REQ-023 SHALL drive stall=1 combinationally when all of the following hold: id_valid; EX.valid & EX.mem_read & EX.reg_write; EX.rd!=0; and (id_rs1==EX.rd or id_rs2==EX.rd); and flush=0.
REQ-024 SHALL advance WB<=MEM and MEM<=EX on every clock; the stages never freeze.
REQ-025 SHALL load EX from the id_* inputs on a normal clock, with EX.valid<=id_valid.
REQ-026 SHALL load a bubble (EX.valid<=0) into EX when stall=1; the decode instruction is re-presented by upstream on the next cycle.
REQ-027 SHALL, when flush=1, load a bubble into EX, ignore the decode instruction, and leave MEM and WB to advance normally; flush overrides stall.
REQ-028 SHALL bound any load-use stall to exactly 1 cycle; after it, the dependent instruction resolves with select 10.
REQ-029 SHALL increment stall_count by 1 on each clock where stall=1, saturating at all-ones with no wrap.
REQ-030 SHALL drive ex_valid = EX.valid.

Reset
REQ-031 SHALL, on any clock with rst=1, clear EX.valid, MEM.valid, WB.valid and stall_count, with priority over flush and stall.
REQ-032 SHALL, in the cycle after reset, present stall=0, ex_sel_a=ex_sel_b=00, ex_valid=0 and stall_count=0.
REQ-033 SHALL, when reset is asserted mid-stall, discard the pending bubble and the dependent instruction.

Structure
REQ-034 SHALL take the select-encoding enum (FWD_REG, FWD_EXMEM, FWD_MEMWB) from the core's shared package; the operand mux uses the same type.
REQ-035 SHALL take REG_ADDR_WIDTH's default value from the same package.
REQ-036 SHALL use one sub-module, forward_cmp, which maps one source index plus the MEM and WB state to a select code, instantiated once per operand.

Verification
REQ-037 Stimulus: "add x5" then "sub x6,x5,x1" back-to-back -> response: ex_sel_a=01 while sub is in EX; stall=0.
REQ-038 Stimulus: add x5, then nop, then use of x5 in rs2 -> response: ex_sel_b=10 for one cycle.
REQ-039 Stimulus: writes to x7 in both MEM and WB, and EX rs1=x7 -> response: ex_sel_a=01 (MEM priority).
REQ-040 Stimulus: "lw x3" immediately followed by "add x4,x3,x3" -> response: stall=1 for exactly one cycle, then ex_sel_a=ex_sel_b=10, and stall_count goes 0->1.
REQ-041 Stimulus: write to x0 followed by a reader of x0 -> response: selects stay 00.
REQ-042 Stimulus: load-use hazard with flush=1 in the same cycle -> response: stall=0, ex_valid=0 next cycle, stall_count unchanged; rst pulsed mid-sequence -> response: all outputs at reset values next cycle.

Source files
------------

// File: rtl/forward_ctrl_pkg.sv
// Shared pipeline definitions: operand-forwarding select encoding and register index width.
// Used by the hazard/forwarding control and the EX-stage operand mux.
package forward_ctrl_pkg;

    localparam int REG_ADDR_WIDTH_DEFAULT = 5;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/forward_cmp.sv
// Maps one EX source register against MEM/WB writers to an operand select code.
// Purely combinational; no backpressure.
module forward_cmp
    import forward_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
) (
    input  logic                      ex_valid,
    input  logic [REG_ADDR_WIDTH-1:0] src,
    input  logic                      mem_valid,
    input  logic                      mem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic                      wb_valid,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [1:0]                sel
);

    logic     mem_hit;
    logic     wb_hit;
    fwd_sel_e sel_e;

    // x0 is hardwired to zero, so a write to it must never be forwarded
    assign mem_hit = mem_valid && mem_reg_write && (mem_rd != '0) && (mem_rd == src);
    assign wb_hit  = wb_valid  && wb_reg_write  && (wb_rd  != '0) && (wb_rd  == src);

    always_comb begin
        sel_e = FWD_REG;
        if (ex_valid) begin
            if (mem_hit) begin
                sel_e = FWD_EXMEM;
            end else if (wb_hit) begin
                sel_e = FWD_MEMWB;
            end
        end
    end

    assign sel = sel_e;

endmodule

// File: rtl/forward_ctrl.sv
// Tracks EX/MEM/WB occupancy to drive operand forwarding selects and load-use stalls.
// Selects/stall are combinational from registered state; a load-use inserts exactly one EX bubble.
module forward_ctrl
    import forward_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      flush,
    output logic                      stall,
    output logic [1:0]                ex_sel_a,
    output logic [1:0]                ex_sel_b,
    output logic                      ex_valid,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    logic                      ex_v;
    logic [REG_ADDR_WIDTH-1:0] ex_rs1;
    logic [REG_ADDR_WIDTH-1:0] ex_rs2;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_reg_write;
    logic                      ex_mem_read;

    logic                      mem_v;
    logic [REG_ADDR_WIDTH-1:0] mem_rd;
    logic                      mem_reg_write;

    logic                      wb_v;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic                      wb_reg_write;

    logic                      ex_is_load;

    // A load's data only exists after MEM, so a dependent decode instruction must wait one cycle
    assign ex_is_load = ex_v && ex_mem_read && ex_reg_write && (ex_rd != '0);
    assign stall      = id_valid && ex_is_load && !flush &&
                        ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));

    assign ex_valid = ex_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v        <= 1'b0;
            mem_v       <= 1'b0;
            wb_v        <= 1'b0;
            stall_count <= '0;
        end else begin
            wb_v          <= mem_v;
            wb_rd         <= mem_rd;
            wb_reg_write  <= mem_reg_write;

            mem_v         <= ex_v;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;

            // Payload is loaded unconditionally; only the valid bit decides whether EX is live
            ex_v          <= id_valid && !flush && !stall;
            ex_rs1        <= id_rs1;
            ex_rs2        <= id_rs2;
            ex_rd         <= id_rd;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;

            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_WIDTH'(1);
            end
        end
    end

    forward_cmp #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_cmp_a (
        .ex_valid      (ex_v),
        .src           (ex_rs1),
        .mem_valid     (mem_v),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_valid      (wb_v),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .sel           (ex_sel_a)
    );

    forward_cmp #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_cmp_b (
        .ex_valid      (ex_v),
        .src           (ex_rs2),
        .mem_valid     (mem_v),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_valid      (wb_v),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .sel           (ex_sel_b)
    );

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed vector bench for forward_ctrl, plus a narrow-counter instance to exercise saturation.
module tb_forward_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;

    logic        stall;
    logic [1:0]  ex_sel_a;
    logic [1:0]  ex_sel_b;
    logic        ex_valid;
    logic [31:0] stall_count;

    logic        s_stall;
    logic [1:0]  s_sel_a;
    logic [1:0]  s_sel_b;
    logic        s_ex_valid;
    logic [1:0]  s_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    forward_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (stall),
        .ex_sel_a     (ex_sel_a),
        .ex_sel_b     (ex_sel_b),
        .ex_valid     (ex_valid),
        .stall_count  (stall_count)
    );

    forward_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (s_stall),
        .ex_sel_a     (s_sel_a),
        .ex_sel_b     (s_sel_b),
        .ex_valid     (s_ex_valid),
        .stall_count  (s_count)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       fl;
        logic       rs;
        logic       e_stall;
        logic [1:0] e_a;
        logic [1:0] e_b;
        logic       e_exv;
        int         e_cnt;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t mk(input logic v, input int rs1, input int rs2, input int rd,
                                input logic rw, input logic mr, input logic fl, input logic rs,
                                input logic e_stall, input int e_a, input int e_b,
                                input logic e_exv, input int e_cnt);
        vec_t r;
        r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
        r.rw = rw; r.mr = mr; r.fl = fl; r.rs = rs;
        r.e_stall = e_stall; r.e_a = 2'(e_a); r.e_b = 2'(e_b);
        r.e_exv = e_exv; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr,
                         input logic fl, input logic rs);
        @(posedge clk);
        #1;
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr; flush = fl; rst = rs;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;

        //            v rs1 rs2 rd rw mr fl rs | stall a b exv cnt
        tbl[0]  = mk(0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0);  // reset state
        tbl[1]  = mk(1, 1, 2, 5,  1, 0, 0, 0,   0, 0, 0, 0, 0);  // add x5
        tbl[2]  = mk(1, 5, 1, 6,  1, 0, 0, 0,   0, 0, 0, 1, 0);  // sub x6,x5,x1
        tbl[3]  = mk(0, 0, 0, 0,  0, 0, 0, 0,   0, 1, 0, 1, 0);  // sub in EX: A from EX/MEM
        tbl[4]  = mk(1, 3, 4, 5,  1, 0, 0, 0,   0, 0, 0, 0, 0);  // add x5
        tbl[5]  = mk(0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 1, 0);  // nop
        tbl[6]  = mk(1, 9, 5, 8,  1, 0, 0, 0,   0, 0, 0, 0, 0);  // or x8,x9,x5
        tbl[7]  = mk(0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 2, 1, 0);  // B from MEM/WB
        tbl[8]  = mk(1, 1, 0, 7,  1, 0, 0, 0,   0, 0, 0, 0, 0);  // write x7
        tbl[9]  = mk(1, 2, 0, 7,  1, 0, 0, 0,   0, 0, 0, 1, 0);  // write x7 again
        tbl[10] = mk(1, 7, 3, 10, 1, 0, 0, 0,   0, 0, 0, 1, 0);  // reader of x7
        tbl[11] = mk(0, 0, 0, 0,  0, 0, 0, 0,   0, 1, 0, 1, 0);  // MEM wins over WB
        tbl[12] = mk(1, 7, 0, 0,  1, 0, 0, 0,   0, 0, 0, 0, 0);  // write x0
        tbl[13] = mk(1, 0, 0, 11, 1, 0, 0, 0,   0, 0, 0, 1, 0);  // reader of x0
        tbl[14] = mk(0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 1, 0);  // x0 never forwards
        tbl[15] = mk(0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0);
        tbl[16] = mk(1, 1, 0, 3,  1, 1, 0, 0,   0, 0, 0, 0, 0);  // lw x3
        tbl[17] = mk(1, 3, 3, 4,  1, 0, 0, 0,   1, 0, 0, 1, 0);  // add x4,x3,x3: stall
        tbl[18] = mk(1, 3, 3, 4,  1, 0, 0, 0,   0, 0, 0, 0, 1);  // re-presented, bubble in EX
        tbl[19] = mk(0, 0, 0, 0,  0, 0, 0, 0,   0, 2, 2, 1, 1);  // both from MEM/WB
        tbl[20] = mk(1, 1, 0, 3,  1, 1, 0, 0,   0, 0, 0, 0, 1);  // lw x3
        tbl[21] = mk(1, 3, 3, 4,  1, 0, 1, 0,   0, 0, 0, 1, 1);  // hazard + flush: no stall
        tbl[22] = mk(0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 1);  // flushed: EX empty
        tbl[23] = mk(1, 1, 0, 3,  1, 1, 0, 0,   0, 0, 0, 0, 1);  // lw x3
        tbl[24] = mk(1, 3, 3, 4,  1, 0, 0, 0,   1, 0, 0, 1, 1);  // stall again
        tbl[25] = mk(1, 3, 3, 4,  1, 0, 0, 1,   0, 0, 0, 0, 2);  // rst mid-stall
        tbl[26] = mk(0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0);  // all back to reset values
        tbl[27] = mk(0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rw, tbl[i].mr,
                  tbl[i].fl, tbl[i].rs);
            check("stall",       i, stall,       tbl[i].e_stall);
            check("ex_sel_a",    i, ex_sel_a,    tbl[i].e_a);
            check("ex_sel_b",    i, ex_sel_b,    tbl[i].e_b);
            check("ex_valid",    i, ex_valid,    tbl[i].e_exv);
            check("stall_count", i, stall_count, tbl[i].e_cnt);
            check("sat_count",   i, s_count,     (tbl[i].e_cnt > 3) ? 3 : tbl[i].e_cnt);
        end

        // Repeated load-use through rs2 only: main counter climbs, 2-bit counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, 3, 1, 1, 0, 0);
            check("loop_lw_stall", 100 + k, stall, 0);
            drive(1, 9, 3, 4, 1, 0, 0, 0);
            check("loop_use_stall", 100 + k, stall, 1);
            check("loop_use_exv", 100 + k, ex_valid, 1);
            drive(1, 9, 3, 4, 1, 0, 0, 0);
            check("loop_bubble_stall", 100 + k, stall, 0);
            check("loop_bubble_exv", 100 + k, ex_valid, 0);
            check("loop_count", 100 + k, stall_count, k + 1);
            check("loop_sat_count", 100 + k, s_count, (k + 1 > 3) ? 3 : k + 1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("loop_resolve_a", 200, ex_sel_a, 0);
        check("loop_resolve_b", 200, ex_sel_b, 2);
        check("final_count", 200, stall_count, 5);
        check("final_sat_count", 200, s_count, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
